// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with a hardware return-address stack.
// Supports inc, absolute jump, relative branch, call/ret, stall, and sticky stack error flags.
module pc_stack_unit #(
  parameter int               WIDTH     = 16,
  parameter int               OFF_W     = 8,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                     PCU_clk,
  input  logic                     PCU_rst,
  input  logic                     PCU_hold,
  input  logic                     PCU_inc,
  input  logic                     PCU_jump,
  input  logic                     PCU_branch,
  input  logic                     PCU_call,
  input  logic                     PCU_ret,
  input  logic                     PCU_clr_err,
  input  logic [WIDTH-1:0]         PCU_in,
  input  logic [OFF_W-1:0]         PCU_off,
  output logic [WIDTH-1:0]         PCU_out,
  output logic [WIDTH-1:0]         PCU_top,
  output logic [$clog2(DEPTH):0]   PCU_sp,
  output logic                     PCU_full,
  output logic                     PCU_empty,
  output logic                     PCU_ovf,
  output logic                     PCU_unf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [AW:0]      sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic             push_en;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] off_ext;
  logic [AW:0]      sp_m1;
  logic             full, empty;

  assign pc_inc  = pc_q + WIDTH'(1);
  assign off_ext = WIDTH'(signed'(PCU_off));
  assign sp_m1   = sp_q - (AW+1)'(1);
  assign full    = (sp_q == (AW+1)'(DEPTH));
  assign empty   = (sp_q == '0);

  // Priority: hold > call > ret > jump > branch > inc; error set beats clear.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (!PCU_hold) begin
      if (PCU_clr_err) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (PCU_call) begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_d    = sp_q + (AW+1)'(1);
          pc_d    = PCU_in;
        end
      end else if (PCU_ret) begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          pc_d = stack_q[sp_m1[AW-1:0]];
          sp_d = sp_m1;
        end
      end else if (PCU_jump) begin
        pc_d = PCU_in;
      end else if (PCU_branch) begin
        pc_d = pc_q + off_ext;
      end else if (PCU_inc) begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge PCU_clk or posedge PCU_rst) begin
    if (PCU_rst) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage is not reset; only sp defines which entries are valid.
  always_ff @(posedge PCU_clk) begin
    if (push_en && !PCU_rst) begin
      stack_q[sp_q[AW-1:0]] <= pc_inc;
    end
  end

  assign PCU_out   = pc_q;
  assign PCU_sp    = sp_q;
  assign PCU_full  = full;
  assign PCU_empty = empty;
  assign PCU_ovf   = ovf_q;
  assign PCU_unf   = unf_q;
  assign PCU_top   = empty ? '0 : stack_q[sp_m1[AW-1:0]];

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: directed vectors on a 16/8/8 instance,
// randomised strobes against a queue-based model on an 8/4/2 instance.
module tb_pc_stack_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_hold, a_inc, a_jump, a_branch, a_call, a_ret, a_clr;
  logic [15:0] a_in;
  logic [7:0]  a_off;
  logic [15:0] a_out, a_top;
  logic [3:0]  a_sp;
  logic        a_full, a_empty, a_ovf, a_unf;

  logic        b_hold, b_inc, b_jump, b_branch, b_call, b_ret, b_clr;
  logic [7:0]  b_in;
  logic [3:0]  b_off;
  logic [7:0]  b_out, b_top;
  logic [1:0]  b_sp;
  logic        b_full, b_empty, b_ovf, b_unf;

  pc_stack_unit #(.WIDTH(16), .OFF_W(8), .DEPTH(8), .RESET_VEC(16'h0010)) dut_a (
    .PCU_clk(clk), .PCU_rst(rst), .PCU_hold(a_hold), .PCU_inc(a_inc), .PCU_jump(a_jump),
    .PCU_branch(a_branch), .PCU_call(a_call), .PCU_ret(a_ret), .PCU_clr_err(a_clr),
    .PCU_in(a_in), .PCU_off(a_off), .PCU_out(a_out), .PCU_top(a_top), .PCU_sp(a_sp),
    .PCU_full(a_full), .PCU_empty(a_empty), .PCU_ovf(a_ovf), .PCU_unf(a_unf));

  pc_stack_unit #(.WIDTH(8), .OFF_W(4), .DEPTH(2), .RESET_VEC(8'h00)) dut_b (
    .PCU_clk(clk), .PCU_rst(rst), .PCU_hold(b_hold), .PCU_inc(b_inc), .PCU_jump(b_jump),
    .PCU_branch(b_branch), .PCU_call(b_call), .PCU_ret(b_ret), .PCU_clr_err(b_clr),
    .PCU_in(b_in), .PCU_off(b_off), .PCU_out(b_out), .PCU_top(b_top), .PCU_sp(b_sp),
    .PCU_full(b_full), .PCU_empty(b_empty), .PCU_ovf(b_ovf), .PCU_unf(b_unf));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic [15:0] pc;
    logic [3:0]  sp;
    logic [15:0] top;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // command bit order: {hold, call, ret, jump, branch, inc, clr}
  localparam logic [6:0] H = 7'b1000000, C = 7'b0100000, R = 7'b0010000,
                         J = 7'b0001000, B = 7'b0000100, I = 7'b0000010,
                         X = 7'b0000001, N = 7'b0000000;

  exp_t ea, eb;
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk({ea.nm, " pc"}, 32'(a_out), 32'(ea.pc));
      chk({ea.nm, " sp"}, 32'(a_sp), 32'(ea.sp));
      chk({ea.nm, " top"}, 32'(a_top), 32'(ea.top));
      chk({ea.nm, " flags"}, 32'({a_full, a_empty, a_ovf, a_unf}),
          32'({ea.sp == 4'd8, ea.sp == 4'd0, ea.ovf, ea.unf}));
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk({eb.nm, " pc"}, 32'(b_out), 32'(eb.pc));
      chk({eb.nm, " sp"}, 32'(b_sp), 32'(eb.sp));
      chk({eb.nm, " top"}, 32'(b_top), 32'(eb.top));
      chk({eb.nm, " flags"}, 32'({b_full, b_empty, b_ovf, b_unf}),
          32'({eb.sp == 4'd2, eb.sp == 4'd0, eb.ovf, eb.unf}));
    end
  end

  task automatic step_a(input string nm, input logic [6:0] cmd, input logic [15:0] in,
                        input logic [7:0] off, input logic [15:0] e_pc, input logic [3:0] e_sp,
                        input logic [15:0] e_top, input logic e_ovf, input logic e_unf);
    exp_t e;
    @(negedge clk);
    {a_hold, a_call, a_ret, a_jump, a_branch, a_inc, a_clr} = cmd;
    a_in  = in;
    a_off = off;
    e.nm = nm; e.pc = e_pc; e.sp = e_sp; e.top = e_top; e.ovf = e_ovf; e.unf = e_unf;
    qa.push_back(e);
  endtask

  // Behavioural model for the small instance; the stack is a SystemVerilog queue.
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_ovf, m_unf;

  task automatic rand_b();
    exp_t e;
    @(negedge clk);
    b_hold   = ($urandom_range(7) == 0);
    b_call   = ($urandom_range(2) == 0);
    b_ret    = ($urandom_range(2) == 0);
    b_jump   = ($urandom_range(2) == 0);
    b_branch = ($urandom_range(2) == 0);
    b_inc    = ($urandom_range(2) == 0);
    b_clr    = ($urandom_range(5) == 0);
    b_in     = 8'($urandom);
    b_off    = 4'($urandom);
    if (!b_hold) begin
      if (b_clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (b_call) begin
        if (m_stk.size() == 2) m_ovf = 1'b1;
        else begin m_stk.push_back(m_pc + 8'd1); m_pc = b_in; end
      end else if (b_ret) begin
        if (m_stk.size() == 0) m_unf = 1'b1;
        else m_pc = m_stk.pop_back();
      end else if (b_jump) m_pc = b_in;
      else if (b_branch) m_pc = m_pc + {{4{b_off[3]}}, b_off};
      else if (b_inc) m_pc = m_pc + 8'd1;
    end
    e.nm  = "rand_b";
    e.pc  = {8'h00, m_pc};
    e.sp  = 4'(m_stk.size());
    e.top = (m_stk.size() > 0) ? {8'h00, m_stk[m_stk.size()-1]} : 16'h0000;
    e.ovf = m_ovf;
    e.unf = m_unf;
    qb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {a_hold, a_call, a_ret, a_jump, a_branch, a_inc, a_clr} = N;
    {b_hold, b_call, b_ret, b_jump, b_branch, b_inc, b_clr} = N;
    a_in = '0; a_off = '0; b_in = '0; b_off = '0;
    #2;
    chk("reset pc", 32'(a_out), 32'h0010);
    chk("reset sp", 32'(a_sp), 32'h0);
    chk("reset top", 32'(a_top), 32'h0);
    chk("reset flags", 32'({a_full, a_empty, a_ovf, a_unf}), 32'b0100);
    @(negedge clk);
    rst = 1'b0;

    step_a("inc1", I, 16'h0, 8'h0, 16'h0011, 4'd0, 16'h0, 1'b0, 1'b0);
    step_a("inc2", I, 16'h0, 8'h0, 16'h0012, 4'd0, 16'h0, 1'b0, 1'b0);
    step_a("inc3", I, 16'h0, 8'h0, 16'h0013, 4'd0, 16'h0, 1'b0, 1'b0);
    step_a("jump50", J, 16'h0050, 8'h0, 16'h0050, 4'd0, 16'h0, 1'b0, 1'b0);

    // Asynchronous reset with a strobe pending: no edge needed, command discarded.
    @(negedge clk);
    {a_hold, a_call, a_ret, a_jump, a_branch, a_inc, a_clr} = I;
    rst = 1'b1;
    #1;
    chk("async_rst pc", 32'(a_out), 32'h0010);
    chk("async_rst sp", 32'(a_sp), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    {a_hold, a_call, a_ret, a_jump, a_branch, a_inc, a_clr} = N;
    #1;
    chk("rst_discard pc", 32'(a_out), 32'h0010);
    step_a("post_rst_inc", I, 16'h0, 8'h0, 16'h0011, 4'd0, 16'h0, 1'b0, 1'b0);

    step_a("jmp_ffff", J, 16'hFFFF, 8'h0, 16'hFFFF, 4'd0, 16'h0, 1'b0, 1'b0);
    step_a("inc_wrap", I, 16'h0, 8'h0, 16'h0000, 4'd0, 16'h0, 1'b0, 1'b0);
    step_a("jmp_0002", J, 16'h0002, 8'h0, 16'h0002, 4'd0, 16'h0, 1'b0, 1'b0);
    step_a("br_neg_wrap", B, 16'h0, 8'hFC, 16'hFFFE, 4'd0, 16'h0, 1'b0, 1'b0);
    step_a("jmp_fff0", J, 16'hFFF0, 8'h0, 16'hFFF0, 4'd0, 16'h0, 1'b0, 1'b0);
    step_a("br_pos_wrap", B, 16'h0, 8'h7F, 16'h006F, 4'd0, 16'h0, 1'b0, 1'b0);

    step_a("jmp_0100", J, 16'h0100, 8'h0, 16'h0100, 4'd0, 16'h0, 1'b0, 1'b0);
    step_a("call_0200", C, 16'h0200, 8'h0, 16'h0200, 4'd1, 16'h0101, 1'b0, 1'b0);
    step_a("call_0300", C, 16'h0300, 8'h0, 16'h0300, 4'd2, 16'h0201, 1'b0, 1'b0);
    step_a("ret1", R, 16'h0, 8'h0, 16'h0201, 4'd1, 16'h0101, 1'b0, 1'b0);
    step_a("ret2", R, 16'h0, 8'h0, 16'h0101, 4'd0, 16'h0000, 1'b0, 1'b0);

    // Nine calls: call i targets 0x1000+i-1 and pushes the previous PC+1.
    for (int i = 1; i <= 8; i++)
      step_a("call_fill", C, 16'(16'h1000 + i - 1), 8'h0, 16'(16'h1000 + i - 1), 4'(i),
             (i == 1) ? 16'h0102 : 16'(16'h1000 + i - 1), 1'b0, 1'b0);
    step_a("call_ovf", C, 16'h1008, 8'h0, 16'h1007, 4'd8, 16'h1007, 1'b1, 1'b0);
    for (int j = 1; j <= 8; j++)
      step_a("ret_drain", R, 16'h0, 8'h0, (j <= 7) ? 16'(16'h1008 - j) : 16'h0102, 4'(8 - j),
             (j <= 6) ? 16'(16'h1007 - j) : ((j == 7) ? 16'h0102 : 16'h0000), 1'b1, 1'b0);
    step_a("ret_unf", R, 16'h0, 8'h0, 16'h0102, 4'd0, 16'h0, 1'b1, 1'b1);
    step_a("clr_err", X, 16'h0, 8'h0, 16'h0102, 4'd0, 16'h0, 1'b0, 1'b0);

    step_a("prio_call", C | J | I, 16'h0400, 8'h0, 16'h0400, 4'd1, 16'h0103, 1'b0, 1'b0);
    step_a("hold_ret", H | R, 16'h0, 8'h0, 16'h0400, 4'd1, 16'h0103, 1'b0, 1'b0);
    for (int k = 2; k <= 8; k++)
      step_a("call_self", C, 16'h0400, 8'h0, 16'h0400, 4'(k), 16'h0401, 1'b0, 1'b0);
    step_a("ovf_beats_clr", C | X, 16'h0500, 8'h0, 16'h0400, 4'd8, 16'h0401, 1'b1, 1'b0);
    step_a("hold_clr", H | X, 16'h0, 8'h0, 16'h0400, 4'd8, 16'h0401, 1'b1, 1'b0);
    step_a("clr_ovf", X, 16'h0, 8'h0, 16'h0400, 4'd8, 16'h0401, 1'b0, 1'b0);
    step_a("prio_ret", R | J, 16'h0777, 8'h0, 16'h0401, 4'd7, 16'h0401, 1'b0, 1'b0);
    step_a("prio_jump", J | B | I, 16'h0020, 8'h03, 16'h0020, 4'd7, 16'h0401, 1'b0, 1'b0);
    step_a("prio_branch", B | I, 16'h0, 8'h03, 16'h0023, 4'd7, 16'h0401, 1'b0, 1'b0);
    step_a("idle", N, 16'h0, 8'h0, 16'h0023, 4'd7, 16'h0401, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    {a_hold, a_call, a_ret, a_jump, a_branch, a_inc, a_clr} = N;
    @(negedge clk);
    rst = 1'b0;
    m_pc = 8'h00; m_ovf = 1'b0; m_unf = 1'b0; m_stk.delete();
    for (int n = 0; n < 300; n++) rand_b();
    @(negedge clk);
    {b_hold, b_call, b_ret, b_jump, b_branch, b_inc, b_clr} = N;

    repeat (3) @(negedge clk);
    if (qa.size() != 0 || qb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: pending %0d/%0d required 0/0", qa.size(), qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
